audio_out_mc: RTL

//  Multi-channel audio output stage that generalises the stereo output path to NUM_CH channels of SAMPLE_W bits.
//  - Generates a fractional-rate sample strobe from clk.
//  - Deglitches the core samples, converts unsigned samples to signed, and holds the channels muted for a startup period.
//  - Applies a click-free volume/mute ramp, using one shared multiplier time-multiplexed across the channels.
//  - Sits between the sound cores and the HDMI/I2S serialisers.

---
 rtl/audio_out_pkg.sv | 27 ++
 rtl/audio_rate_gen.sv | 29 ++
 rtl/audio_out_mc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/audio_out_pkg.sv
// Shared types and helpers for the multi-channel audio output stage.
package audio_out_pkg;

  localparam int GAIN_W = 9;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Move cur toward tgt by at most step, landing exactly on tgt.
  function automatic logic [GAIN_W-1:0] gain_step(
    input logic [GAIN_W-1:0] cur,
    input logic [GAIN_W-1:0] tgt,
    input logic [GAIN_W-1:0] step
  );
    if (cur < tgt)
      return ((tgt - cur) > step) ? cur + step : tgt;
    else if (cur > tgt)
      return ((cur - tgt) > step) ? cur - step : tgt;
    else
      return cur;
  endfunction

endpackage

// File: rtl/audio_rate_gen.sv
// Fractional-rate strobe generator: accumulates rate, wraps modulo CLK_RATE.
// One registered strobe per wrap; a rate of CLK_RATE or more strobes every clk.
module audio_rate_gen #(
  parameter int CLK_RATE = 24576000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_rate,
  output logic        o_ce
);

  logic [31:0] r_acc;
  logic [32:0] w_sum;
  logic        w_wrap;

  assign w_sum  = {1'b0, r_acc} + {1'b0, i_rate};
  assign w_wrap = (w_sum >= 33'(CLK_RATE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      o_ce  <= 1'b0;
    end else begin
      r_acc <= w_wrap ? 32'(w_sum - 33'(CLK_RATE)) : w_sum[31:0];
      o_ce  <= w_wrap;
    end
  end

endmodule

// File: rtl/audio_out_mc.sv
// Multi-channel output stage: deglitch, sign fix, startup mute, gain ramp on one shared multiplier.
// out_valid follows an accepted sample_ce by NUM_CH+2 clk; strobes arriving while busy are dropped and flagged.
module audio_out_mc
  import audio_out_pkg::*;
#(
  parameter int CLK_RATE        = 24576000,
  parameter int NUM_CH          = 2,
  parameter int SAMPLE_W        = 16,
  parameter int STARTUP_SAMPLES = 1024,
  parameter int RAMP_STEP       = 1,
  parameter int ENABLE          = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  i_rate,
  input  logic                         i_is_signed,
  input  logic [8:0]                   i_volume,
  input  logic                         i_mute,
  input  logic [NUM_CH*SAMPLE_W-1:0]   i_core_in,
  input  logic                         i_overrun_clr,
  output logic [NUM_CH*SAMPLE_W-1:0]   o_audio_out,
  output logic                         o_out_valid,
  output logic                         o_sample_ce,
  output logic                         o_active,
  output logic                         o_overrun
);

  localparam int DW     = NUM_CH * SAMPLE_W;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = (STARTUP_SAMPLES > 0) ? $clog2(STARTUP_SAMPLES + 1) : 1;
  localparam int PROD_W = SAMPLE_W + 10;
  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

  logic w_ce;

  audio_rate_gen #(.CLK_RATE(CLK_RATE)) u_rate_gen (
    .clk   (clk),
    .reset (reset),
    .i_rate(i_rate),
    .o_ce  (w_ce)
  );

  logic [DW-1:0] r_d1, r_d2, r_held, w_conv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d1   <= '0;
      r_d2   <= '0;
      r_held <= '0;
    end else begin
      r_d1 <= i_core_in;
      r_d2 <= r_d1;
      for (int c = 0; c < NUM_CH; c++)
        if (r_d1[c*SAMPLE_W +: SAMPLE_W] == r_d2[c*SAMPLE_W +: SAMPLE_W])
          r_held[c*SAMPLE_W +: SAMPLE_W] <= r_d2[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Offset binary becomes two's complement by flipping each channel's MSB.
  always_comb begin
    w_conv = r_held;
    for (int c = 0; c < NUM_CH; c++)
      w_conv[c*SAMPLE_W + SAMPLE_W - 1] = r_held[c*SAMPLE_W + SAMPLE_W - 1] ^ ~i_is_signed;
  end

  logic [CNT_W-1:0]  r_start_cnt;
  logic              r_active;
  logic              w_active_nxt;
  logic [GAIN_W-1:0] r_gain, r_fgain, w_vol, w_target, w_gain_nxt;

  assign w_active_nxt = r_active | (r_start_cnt >= CNT_W'(STARTUP_SAMPLES - 1));
  assign w_vol        = (i_volume > GAIN_UNITY) ? GAIN_UNITY : i_volume;
  assign w_target     = (i_mute | ~w_active_nxt) ? '0 : w_vol;
  assign w_gain_nxt   = gain_step(r_gain, w_target, STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_cnt <= '0;
      r_active    <= 1'b0;
      r_gain      <= '0;
    end else if (w_ce) begin
      if (r_start_cnt != CNT_W'(STARTUP_SAMPLES))
        r_start_cnt <= r_start_cnt + CNT_W'(1);
      r_active <= w_active_nxt;
      r_gain   <= w_gain_nxt;
    end
  end

  state_t                     r_state;
  logic [CH_W-1:0]            r_ch;
  logic [DW-1:0]              r_frame, r_shadow, r_audio;
  logic                       r_valid, r_overrun;
  logic signed [SAMPLE_W-1:0] w_sample;
  logic signed [PROD_W-1:0]   w_prod;
  logic [SAMPLE_W-1:0]        w_result;

  // The one multiplier, steered to the current channel; bits above 8 give floor(prod / 256).
  assign w_sample = r_frame[r_ch*SAMPLE_W +: SAMPLE_W];
  assign w_prod   = PROD_W'(w_sample) * PROD_W'($signed({1'b0, r_fgain}));
  assign w_result = w_prod[8 +: SAMPLE_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_frame   <= '0;
      r_shadow  <= '0;
      r_audio   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_fgain   <= '0;
    end else begin
      r_valid <= 1'b0;
      if (i_overrun_clr)
        r_overrun <= 1'b0;
      else if (w_ce && (r_state != IDLE))
        r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (w_ce) begin
          r_frame <= w_conv;
          r_fgain <= w_gain_nxt;
          r_ch    <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_shadow[r_ch*SAMPLE_W +: SAMPLE_W] <= w_result;
          if (r_ch == CH_W'(NUM_CH - 1))
            r_state <= DONE;
          else
            r_ch <= r_ch + CH_W'(1);
        end
        DONE: begin
          r_audio <= r_shadow;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_audio_out = (ENABLE != 0) ? r_audio : i_core_in;
  assign o_out_valid = (ENABLE != 0) ? r_valid : w_ce;
  assign o_overrun   = (ENABLE != 0) ? r_overrun : 1'b0;
  assign o_sample_ce = w_ce;
  assign o_active    = r_active;

endmodule
